// File: rtl/tlb_array_pkg.sv
// Shared field layout and page helpers for the JTLB entry array.
package tlb_array_pkg;

  localparam int TLB_ENTRY_W = 78;
  localparam int VPN2_W      = 19;
  localparam int ASID_W      = 8;
  localparam int PAGE_W      = 25;

  // Entry layout: [77:59] VPN2, [58:51] ASID, [50] G, [49:25] even page, [24:0] odd page
  localparam int VPN2_LSB = 59;
  localparam int ASID_LSB = 51;
  localparam int G_BIT    = 50;
  localparam int LO0_LSB  = 25;
  localparam int LO1_LSB  = 0;

  // Page word: {PFN, C, D, V} with V at the LSB
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } page_t;

  // Pick the even or odd page of an entry using VA[12]
  function automatic page_t select_page(input logic [TLB_ENTRY_W-1:0] e, input logic odd);
    select_page = odd ? page_t'(e[LO1_LSB +: PAGE_W]) : page_t'(e[LO0_LSB +: PAGE_W]);
  endfunction

endpackage

// File: rtl/tlb_array_match.sv
// Parallel tag compare of one search key against every TLB entry.
module tlb_array_match
  import tlb_array_pkg::*;
#(
  parameter int TLBNUM = 16
) (
  input  logic [VPN2_W-1:0]        vpn2_i,
  input  logic [ASID_W-1:0]        asid_i,
  input  logic [TLBNUM*VPN2_W-1:0] vpn2_arr_i,
  input  logic [TLBNUM*ASID_W-1:0] asid_arr_i,
  input  logic [TLBNUM-1:0]        g_arr_i,
  output logic [TLBNUM-1:0]        match_o
);

  // Entry matches on VPN2, and on ASID unless the entry is global
  always_comb begin
    match_o = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match_o[i] = (vpn2_arr_i[i*VPN2_W +: VPN2_W] == vpn2_i) &&
                   (g_arr_i[i] || (asid_arr_i[i*ASID_W +: ASID_W] == asid_i));
    end
  end

endmodule

// File: rtl/tlb_array.sv
// Fully associative MIPS-style JTLB: two combinational lookup ports,
// registered tlbp probe and tlbr read results, tlbwi entry write.
module tlb_array
  import tlb_array_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  // fetch lookup port
  input  logic [VPN2_W-1:0]      s0_vpn2,
  input  logic                   s0_odd,
  input  logic [ASID_W-1:0]      s0_asid,
  output logic                   s0_found,
  output logic [IDXW-1:0]        s0_index,
  output logic [19:0]            s0_pfn,
  output logic [2:0]             s0_c,
  output logic                   s0_d,
  output logic                   s0_v,
  // load/store lookup port
  input  logic [VPN2_W-1:0]      s1_vpn2,
  input  logic                   s1_odd,
  input  logic [ASID_W-1:0]      s1_asid,
  output logic                   s1_found,
  output logic [IDXW-1:0]        s1_index,
  output logic [19:0]            s1_pfn,
  output logic [2:0]             s1_c,
  output logic                   s1_d,
  output logic                   s1_v,
  // tlbwi
  input  logic                   tlbwi_we,
  input  logic [IDXW-1:0]        tlbwi_index,
  input  logic [TLB_ENTRY_W-1:0] tlbwi_entry,
  // tlbp
  input  logic                   tlbp_req,
  input  logic [31:0]            tlbp_entryhi,
  output logic                   tlbp_wen,
  output logic [31:0]            tlbp_index,
  // tlbr
  input  logic                   tlbr_req,
  input  logic [IDXW-1:0]        tlbr_index,
  output logic                   tlbr_wen,
  output logic [TLB_ENTRY_W-1:0] tlbr_entry
);

  logic [TLB_ENTRY_W-1:0]  entry_q [TLBNUM];
  logic [TLBNUM*VPN2_W-1:0] vpn2_flat;
  logic [TLBNUM*ASID_W-1:0] asid_flat;
  logic [TLBNUM-1:0]        g_flat;

  logic [TLBNUM-1:0] s0_match, s1_match, p_match;
  logic [IDXW-1:0]   s0_idx, s1_idx, p_idx;
  page_t             s0_pg, s1_pg;

  logic                   tlbp_wen_q, tlbr_wen_q;
  logic [31:0]            tlbp_index_q, tlbp_index_d;
  logic [TLB_ENTRY_W-1:0] tlbr_entry_q;

  // EntryHi bits [12:8] carry no tag information
  logic unused_entryhi;
  assign unused_entryhi = ^tlbp_entryhi[12:8];

  // Lowest matching index wins when software leaves duplicate entries
  function automatic logic [IDXW-1:0] lowest_idx(input logic [TLBNUM-1:0] m);
    lowest_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDXW'(i);
    end
  endfunction

  // Entry storage: cleared on reset, one entry written per tlbwi
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLBNUM; i++) entry_q[i] <= '0;
    end else if (tlbwi_we) begin
      entry_q[tlbwi_index] <= tlbwi_entry;
    end
  end

  // Flatten tag fields for the comparators
  always_comb begin
    vpn2_flat = '0;
    asid_flat = '0;
    g_flat    = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      vpn2_flat[i*VPN2_W +: VPN2_W] = entry_q[i][VPN2_LSB +: VPN2_W];
      asid_flat[i*ASID_W +: ASID_W] = entry_q[i][ASID_LSB +: ASID_W];
      g_flat[i]                     = entry_q[i][G_BIT];
    end
  end

  tlb_array_match #(.TLBNUM(TLBNUM)) u_match_s0 (
    .vpn2_i(s0_vpn2), .asid_i(s0_asid),
    .vpn2_arr_i(vpn2_flat), .asid_arr_i(asid_flat), .g_arr_i(g_flat),
    .match_o(s0_match)
  );

  tlb_array_match #(.TLBNUM(TLBNUM)) u_match_s1 (
    .vpn2_i(s1_vpn2), .asid_i(s1_asid),
    .vpn2_arr_i(vpn2_flat), .asid_arr_i(asid_flat), .g_arr_i(g_flat),
    .match_o(s1_match)
  );

  tlb_array_match #(.TLBNUM(TLBNUM)) u_match_p (
    .vpn2_i(tlbp_entryhi[31:13]), .asid_i(tlbp_entryhi[7:0]),
    .vpn2_arr_i(vpn2_flat), .asid_arr_i(asid_flat), .g_arr_i(g_flat),
    .match_o(p_match)
  );

  // Fetch port: found ignores V; a miss drives index and page fields to zero
  always_comb begin
    s0_found = |s0_match;
    s0_idx   = lowest_idx(s0_match);
    s0_pg    = '0;
    if (s0_found) s0_pg = select_page(entry_q[s0_idx], s0_odd);
  end

  // Data port: same selection as the fetch port
  always_comb begin
    s1_found = |s1_match;
    s1_idx   = lowest_idx(s1_match);
    s1_pg    = '0;
    if (s1_found) s1_pg = select_page(entry_q[s1_idx], s1_odd);
  end

  assign s0_index = s0_idx;
  assign s0_pfn   = s0_pg.pfn;
  assign s0_c     = s0_pg.c;
  assign s0_d     = s0_pg.d;
  assign s0_v     = s0_pg.v;
  assign s1_index = s1_idx;
  assign s1_pfn   = s1_pg.pfn;
  assign s1_c     = s1_pg.c;
  assign s1_d     = s1_pg.d;
  assign s1_v     = s1_pg.v;

  // Probe result word: P bit set on miss, otherwise the hit index
  always_comb begin
    p_idx        = lowest_idx(p_match);
    tlbp_index_d = '0;
    if (|p_match) tlbp_index_d[IDXW-1:0] = p_idx;
    else          tlbp_index_d[31]       = 1'b1;
  end

  // Probe result register: pulse next cycle, value held between probes
  always_ff @(posedge clk) begin
    if (rst) begin
      tlbp_wen_q   <= 1'b0;
      tlbp_index_q <= '0;
    end else begin
      tlbp_wen_q <= tlbp_req;
      if (tlbp_req) tlbp_index_q <= tlbp_index_d;
    end
  end

  // Read result register: pulse next cycle, value held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      tlbr_wen_q   <= 1'b0;
      tlbr_entry_q <= '0;
    end else begin
      tlbr_wen_q <= tlbr_req;
      if (tlbr_req) tlbr_entry_q <= entry_q[tlbr_index];
    end
  end

  // A result still in flight when reset rises must not pulse into CP0
  assign tlbp_wen   = tlbp_wen_q & ~rst;
  assign tlbp_index = tlbp_index_q;
  assign tlbr_wen   = tlbr_wen_q & ~rst;
  assign tlbr_entry = tlbr_entry_q;

endmodule

// File: tb/tb_tlb_array.sv
// Directed bench for tlb_array: lookups, tlbwi, tlbp, tlbr, hazards, reset.
module tb_tlb_array;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd, s1_odd;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [IDXW-1:0] s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        tlbwi_we;
  logic [IDXW-1:0] tlbwi_index;
  logic [77:0] tlbwi_entry;
  logic        tlbp_req;
  logic [31:0] tlbp_entryhi;
  logic        tlbp_wen;
  logic [31:0] tlbp_index;
  logic        tlbr_req;
  logic [IDXW-1:0] tlbr_index;
  logic        tlbr_wen;
  logic [77:0] tlbr_entry;

  int checks = 0;
  int errors = 0;

  logic [77:0] e3, e3g, e7, e_dup2, e_dup9;

  always #5 clk = ~clk;

  tlb_array #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .rst(rst),
    .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .tlbwi_we(tlbwi_we), .tlbwi_index(tlbwi_index), .tlbwi_entry(tlbwi_entry),
    .tlbp_req(tlbp_req), .tlbp_entryhi(tlbp_entryhi),
    .tlbp_wen(tlbp_wen), .tlbp_index(tlbp_index),
    .tlbr_req(tlbr_req), .tlbr_index(tlbr_index),
    .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry)
  );

  function automatic logic [24:0] mk_page(input logic [19:0] pfn, input logic [2:0] c,
                                          input logic d, input logic v);
    return {pfn, c, d, v};
  endfunction

  function automatic logic [77:0] mk_entry(input logic [18:0] vpn2, input logic [7:0] asid,
                                           input logic g, input logic [24:0] lo0,
                                           input logic [24:0] lo1);
    return {vpn2, asid, g, lo0, lo1};
  endfunction

  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [IDXW-1:0] idx, input logic [77:0] e);
    tlbwi_we = 1'b1; tlbwi_index = idx; tlbwi_entry = e;
    step();
    tlbwi_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s0_vpn2 = '0; s0_odd = 1'b0; s0_asid = '0;
    s1_vpn2 = '0; s1_odd = 1'b0; s1_asid = '0;
    tlbwi_we = 1'b0; tlbwi_index = '0; tlbwi_entry = '0;
    tlbp_req = 1'b0; tlbp_entryhi = '0;
    tlbr_req = 1'b0; tlbr_index = '0;

    e3     = mk_entry(19'h00200, 8'h05, 1'b0, mk_page(20'h12345, 3'd3, 1'b1, 1'b1),
                      mk_page(20'h0abcd, 3'd2, 1'b0, 1'b0));
    e3g    = mk_entry(19'h00200, 8'h05, 1'b1, mk_page(20'h12345, 3'd3, 1'b1, 1'b1),
                      mk_page(20'h0abcd, 3'd2, 1'b0, 1'b0));
    e7     = mk_entry(19'h7ffff, 8'ha5, 1'b1, mk_page(20'hfedcb, 3'd5, 1'b0, 1'b1),
                      mk_page(20'h13579, 3'd6, 1'b1, 1'b1));
    e_dup2 = mk_entry(19'h12345, 8'h01, 1'b0, mk_page(20'h22222, 3'd1, 1'b0, 1'b1),
                      mk_page(20'h0, 3'd0, 1'b0, 1'b0));
    e_dup9 = mk_entry(19'h12345, 8'h01, 1'b0, mk_page(20'h99999, 3'd1, 1'b0, 1'b1),
                      mk_page(20'h0, 3'd0, 1'b0, 1'b0));

    step(); step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_tlbp_wen",   78'(tlbp_wen),   78'd0);
    chk("rst_tlbp_index", 78'(tlbp_index), 78'd0);
    chk("rst_tlbr_wen",   78'(tlbr_wen),   78'd0);
    chk("rst_tlbr_entry", tlbr_entry,      78'd0);

    // empty TLB: VA 0x0040_0000 misses
    s0_vpn2 = 19'h00200; s0_asid = 8'h00; s0_odd = 1'b0;
    #1;
    chk("empty_s0_found", 78'(s0_found), 78'd0);
    chk("empty_s0_pfn",   78'(s0_pfn),   78'd0);

    tlbp_req = 1'b1; tlbp_entryhi = 32'h0040_0000;
    step();
    tlbp_req = 1'b0;
    chk("miss_tlbp_wen",   78'(tlbp_wen),   78'd1);
    chk("miss_tlbp_index", 78'(tlbp_index), 78'h8000_0000);
    step();
    chk("tlbp_wen_pulse",  78'(tlbp_wen),   78'd0);
    chk("tlbp_index_hold", 78'(tlbp_index), 78'h8000_0000);

    // entry 3, non-global
    write_entry(4'd3, e3);
    s1_vpn2 = 19'h00200; s1_asid = 8'h05; s1_odd = 1'b0;
    #1;
    chk("e3_even_found", 78'(s1_found), 78'd1);
    chk("e3_even_index", 78'(s1_index), 78'd3);
    chk("e3_even_pfn",   78'(s1_pfn),   78'h12345);
    chk("e3_even_c",     78'(s1_c),     78'd3);
    chk("e3_even_d",     78'(s1_d),     78'd1);
    chk("e3_even_v",     78'(s1_v),     78'd1);
    s1_odd = 1'b1;
    #1;
    chk("e3_odd_found",  78'(s1_found), 78'd1);
    chk("e3_odd_v",      78'(s1_v),     78'd0);
    chk("e3_odd_pfn",    78'(s1_pfn),   78'h0abcd);
    s1_asid = 8'h06; s1_odd = 1'b0;
    #1;
    chk("e3_asid6_found", 78'(s1_found), 78'd0);
    chk("e3_asid6_index", 78'(s1_index), 78'd0);
    chk("e3_asid6_pfn",   78'(s1_pfn),   78'd0);

    // same entry made global
    write_entry(4'd3, e3g);
    #1;
    chk("e3g_asid6_found", 78'(s1_found), 78'd1);
    chk("e3g_asid6_index", 78'(s1_index), 78'd3);
    tlbp_req = 1'b1; tlbp_entryhi = 32'h0040_0009;
    step();
    tlbp_req = 1'b0;
    chk("e3g_tlbp_wen",   78'(tlbp_wen),   78'd1);
    chk("e3g_tlbp_index", 78'(tlbp_index), 78'h0000_0003);

    // write and read of entry 7 in the same cycle: read and lookup see old contents
    tlbwi_we = 1'b1; tlbwi_index = 4'd7; tlbwi_entry = e7;
    tlbr_req = 1'b1; tlbr_index = 4'd7;
    s0_vpn2 = 19'h7ffff; s0_asid = 8'h33;
    #1;
    chk("e7_prewrite_lookup", 78'(s0_found), 78'd0);
    step();
    tlbwi_we = 1'b0;
    chk("e7_same_cycle_wen",   78'(tlbr_wen), 78'd1);
    chk("e7_same_cycle_entry", tlbr_entry,    78'd0);
    chk("e7_post_lookup_idx",  78'(s0_index), 78'd7);
    step();
    tlbr_req = 1'b0;
    chk("e7_read_wen",   78'(tlbr_wen), 78'd1);
    chk("e7_read_entry", tlbr_entry,    e7);
    step();
    chk("e7_read_wen_low", 78'(tlbr_wen), 78'd0);
    chk("e7_read_hold",    tlbr_entry,    e7);

    // duplicate VPN2 in entries 9 and 2: lowest index wins
    write_entry(4'd9, e_dup9);
    write_entry(4'd2, e_dup2);
    s0_vpn2 = 19'h12345; s0_asid = 8'h01; s0_odd = 1'b0;
    #1;
    chk("dup_s0_index", 78'(s0_index), 78'd2);
    chk("dup_s0_pfn",   78'(s0_pfn),   78'h22222);
    // probe and read together
    tlbp_req = 1'b1; tlbp_entryhi = {19'h12345, 5'b0, 8'h01};
    tlbr_req = 1'b1; tlbr_index = 4'd9;
    step();
    tlbp_req = 1'b0; tlbr_req = 1'b0;
    chk("dup_tlbp_wen",   78'(tlbp_wen),   78'd1);
    chk("dup_tlbp_index", 78'(tlbp_index), 78'h0000_0002);
    chk("dup_tlbr_wen",   78'(tlbr_wen),   78'd1);
    chk("dup_tlbr_entry", tlbr_entry,      e_dup9);

    // probe in flight when reset rises is dropped
    tlbp_req = 1'b1; tlbp_entryhi = 32'h0040_0005;
    step();
    tlbp_req = 1'b0; rst = 1'b1;
    #1;
    chk("rst_drop_wen_now", 78'(tlbp_wen), 78'd0);
    step();
    chk("rst_drop_wen_in_rst", 78'(tlbp_wen), 78'd0);
    rst = 1'b0;
    step();
    chk("rst_drop_wen_after", 78'(tlbp_wen),   78'd0);
    chk("rst_tlbp_index_clr", 78'(tlbp_index), 78'd0);
    s0_vpn2 = 19'h00200; s0_asid = 8'h05;
    s1_vpn2 = 19'h12345; s1_asid = 8'h01;
    #1;
    chk("rst_s0_miss", 78'(s0_found), 78'd0);
    chk("rst_s1_miss", 78'(s1_found), 78'd0);
    s0_vpn2 = 19'h7ffff;
    #1;
    chk("rst_global_miss", 78'(s0_found), 78'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
